mar_wide: RTL and testbench

Parametrised memory address register, successor to the 4-bit SAP-1 MAR, for the SAP-2/3 datapaths.
- Holds an ADDR_W-bit address driven to RAM.
- Loads the address in one cycle from the program counter, or over several cycles from the narrower W bus as little-endian beats.
- Supports post-increment for block and indexed access.
- Q only ever changes atomically, so RAM never sees a half-written address.

---
 rtl/mar_wide.sv | 88 ++++++++
 tb/tb_mar_wide.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mar_wide.sv
// Memory address register for the SAP-2/3 datapaths: parallel load from PC,
// little-endian multi-beat load from the W bus, and post-increment with wrap flag.
module mar_wide #(
   parameter int                ADDR_W     = 16,
   parameter int                BUS_W      = 8,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic [BUS_W-1:0]  D,
   input  logic [ADDR_W-1:0] PC,
   input  logic              load,
   input  logic              load_beat,
   input  logic              inc,
   output logic [ADDR_W-1:0] Q,
   output logic              valid,
   output logic              busy,
   output logic              wrap
);

   localparam int         BEATS     = ADDR_W / BUS_W;
   localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

   typedef enum logic {IDLE, COLLECT} state_e;

   state_e            state_q;
   logic [1:0]        beat_q;
   logic [ADDR_W-1:0] stage_q;
   logic [ADDR_W-1:0] addr_q;
   logic              valid_q;
   logic              busy_q;
   logic              wrap_q;
   logic [ADDR_W-1:0] final_addr;

   // The final beat lands in the top slice; lower slices come from staging.
   // With a single beat this collapses to D itself.
   always_comb begin
      final_addr = stage_q;
      final_addr[ADDR_W-1 -: BUS_W] = D;
   end

   // Priority CLR > load > load_beat > inc; Q is only ever replaced whole.
   always_ff @(posedge CLK) begin
      wrap_q <= 1'b0;
      if (CLR) begin
         addr_q  <= RESET_ADDR;
         stage_q <= '0;
         beat_q  <= 2'd0;
         state_q <= IDLE;
         valid_q <= 1'b1;
         busy_q  <= 1'b0;
      end else if (load) begin
         addr_q  <= PC;
         beat_q  <= 2'd0;
         state_q <= IDLE;
         valid_q <= 1'b1;
         busy_q  <= 1'b0;
      end else if (load_beat) begin
         if (BEATS == 1) begin
            addr_q <= final_addr;
         end else if (state_q == IDLE) begin
            stage_q[BUS_W-1:0] <= D;
            beat_q  <= 2'd1;
            state_q <= COLLECT;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
         end else if (beat_q == LAST_BEAT) begin
            addr_q  <= final_addr;
            beat_q  <= 2'd0;
            state_q <= IDLE;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
         end else begin
            stage_q[beat_q*BUS_W +: BUS_W] <= D;
            beat_q <= beat_q + 2'd1;
         end
      end else if (inc && (state_q == IDLE)) begin
         addr_q <= addr_q + 1'b1;
         wrap_q <= &addr_q;
      end
   end

   assign Q     = addr_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_mar_wide.sv
// Directed scoreboard bench for mar_wide: a 16/8 instance with a non-zero
// reset address and a 4/4 instance exercising the single-beat case.
module tb_mar_wide;

   logic        clk = 1'b0;

   logic        clr16 = 1'b0, load16 = 1'b0, lb16 = 1'b0, inc16 = 1'b0;
   logic [7:0]  d16 = '0;
   logic [15:0] pc16 = '0;
   logic [15:0] q16;
   logic        valid16, busy16, wrap16;

   logic        clr4 = 1'b0, load4 = 1'b0, lb4 = 1'b0, inc4 = 1'b0;
   logic [3:0]  d4 = '0;
   logic [3:0]  pc4 = '0;
   logic [3:0]  q4;
   logic        valid4, busy4, wrap4;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string       tag;
      logic [15:0] q;
      logic        valid;
      logic        busy;
      logic        wrap;
   } exp_t;

   exp_t scoreboard[$];

   always #5 clk = ~clk;

   mar_wide #(.ADDR_W(16), .BUS_W(8), .RESET_ADDR(16'h0100)) dut16 (
      .CLK(clk), .CLR(clr16), .D(d16), .PC(pc16), .load(load16),
      .load_beat(lb16), .inc(inc16), .Q(q16), .valid(valid16),
      .busy(busy16), .wrap(wrap16)
   );

   mar_wide #(.ADDR_W(4), .BUS_W(4), .RESET_ADDR(4'h0)) dut4 (
      .CLK(clk), .CLR(clr4), .D(d4), .PC(pc4), .load(load4),
      .load_beat(lb4), .inc(inc4), .Q(q4), .valid(valid4),
      .busy(busy4), .wrap(wrap4)
   );

   // Pops the oldest expectation and compares it field by field.
   task automatic checkOutput(input bit narrow);
      exp_t        e;
      logic [15:0] oq;
      logic        ov, ob, ow;
      e  = scoreboard.pop_front();
      oq = narrow ? {12'h000, q4} : q16;
      ov = narrow ? valid4 : valid16;
      ob = narrow ? busy4 : busy16;
      ow = narrow ? wrap4 : wrap16;
      vectors++;
      assert (oq === e.q) else begin
         miscompares++;
         $error("[TB] FAIL %s.Q observed=%h expected=%h", e.tag, oq, e.q);
      end
      vectors++;
      assert (ov === e.valid) else begin
         miscompares++;
         $error("[TB] FAIL %s.valid observed=%b expected=%b", e.tag, ov, e.valid);
      end
      vectors++;
      assert (ob === e.busy) else begin
         miscompares++;
         $error("[TB] FAIL %s.busy observed=%b expected=%b", e.tag, ob, e.busy);
      end
      vectors++;
      assert (ow === e.wrap) else begin
         miscompares++;
         $error("[TB] FAIL %s.wrap observed=%b expected=%b", e.tag, ow, e.wrap);
      end
   endtask

   // Drives one cycle of stimulus on the chosen instance, records the
   // expected post-edge outputs, then checks them just after the edge.
   task automatic applyStimulus(input bit narrow, input string tag,
                                input logic clr, input logic ld,
                                input logic lb, input logic in,
                                input logic [15:0] pc, input logic [7:0] d,
                                input logic [15:0] eq, input logic ev,
                                input logic eb, input logic ew);
      exp_t e;
      if (narrow) begin
         clr4 = clr; load4 = ld; lb4 = lb; inc4 = in;
         pc4 = pc[3:0]; d4 = d[3:0];
      end else begin
         clr16 = clr; load16 = ld; lb16 = lb; inc16 = in;
         pc16 = pc; d16 = d;
      end
      e.tag = tag; e.q = eq; e.valid = ev; e.busy = eb; e.wrap = ew;
      scoreboard.push_back(e);
      @(posedge clk);
      #1;
      checkOutput(narrow);
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset and abort of a partial sequence
      applyStimulus(0, "rst1",     1, 0, 0, 0, 16'h0000, 8'h00, 16'h0100, 1, 0, 0);
      applyStimulus(0, "rst2",     1, 0, 0, 0, 16'h0000, 8'h00, 16'h0100, 1, 0, 0);
      applyStimulus(0, "beat55",   0, 0, 1, 0, 16'h0000, 8'h55, 16'h0100, 0, 1, 0);
      applyStimulus(0, "rstAbort", 1, 0, 1, 1, 16'h0000, 8'h99, 16'h0100, 1, 0, 0);
      applyStimulus(0, "beat77",   0, 0, 1, 0, 16'h0000, 8'h77, 16'h0100, 0, 1, 0);
      applyStimulus(0, "beat66",   0, 0, 1, 0, 16'h0000, 8'h66, 16'h6677, 1, 0, 0);
      // Non-consecutive beats
      applyStimulus(0, "beat34",   0, 0, 1, 0, 16'h0000, 8'h34, 16'h6677, 0, 1, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, "idle",  0, 0, 0, 0, 16'hAAAA, 8'hEE, 16'h6677, 0, 1, 0);
      applyStimulus(0, "beat12",   0, 0, 1, 0, 16'h0000, 8'h12, 16'h1234, 1, 0, 0);
      // Parallel load wins over load_beat and inc
      applyStimulus(0, "ldPrio",   0, 1, 1, 1, 16'hBEEF, 8'h99, 16'hBEEF, 1, 0, 0);
      applyStimulus(0, "incBEEF",  0, 0, 0, 1, 16'h0000, 8'h00, 16'hBEF0, 1, 0, 0);
      // inc ignored mid-collect, load aborts
      applyStimulus(0, "beatAA",   0, 0, 1, 0, 16'h0000, 8'hAA, 16'hBEF0, 0, 1, 0);
      applyStimulus(0, "incIgn",   0, 0, 0, 1, 16'h0000, 8'h00, 16'hBEF0, 0, 1, 0);
      applyStimulus(0, "ldAbort",  0, 1, 0, 0, 16'h0F0F, 8'h00, 16'h0F0F, 1, 0, 0);
      applyStimulus(0, "beat01",   0, 0, 1, 0, 16'h0000, 8'h01, 16'h0F0F, 0, 1, 0);
      applyStimulus(0, "beat02",   0, 0, 1, 0, 16'h0000, 8'h02, 16'h0201, 1, 0, 0);
      // Wrap pulse
      applyStimulus(0, "ldFFFE",   0, 1, 0, 0, 16'hFFFE, 8'h00, 16'hFFFE, 1, 0, 0);
      applyStimulus(0, "incFFFF",  0, 0, 0, 1, 16'h0000, 8'h00, 16'hFFFF, 1, 0, 0);
      applyStimulus(0, "incWrap",  0, 0, 0, 1, 16'h0000, 8'h00, 16'h0000, 1, 0, 1);
      applyStimulus(0, "inc0001",  0, 0, 0, 1, 16'h0000, 8'h00, 16'h0001, 1, 0, 0);
      applyStimulus(0, "ldFFFF",   0, 1, 0, 0, 16'hFFFF, 8'h00, 16'hFFFF, 1, 0, 0);
      applyStimulus(0, "incWrap2", 0, 0, 0, 1, 16'h0000, 8'h00, 16'h0000, 1, 0, 1);
      applyStimulus(0, "wrapDrop", 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 1, 0, 0);
      // Single-beat SAP-1 configuration
      applyStimulus(1, "n.rst",    1, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 1, 0, 0);
      applyStimulus(1, "n.beatF",  0, 0, 1, 0, 16'h0000, 8'h0F, 16'h000F, 1, 0, 0);
      applyStimulus(1, "n.incWrap",0, 0, 0, 1, 16'h0000, 8'h00, 16'h0000, 1, 0, 1);
      applyStimulus(1, "n.beat3",  0, 0, 1, 0, 16'h0000, 8'h03, 16'h0003, 1, 0, 0);
      applyStimulus(1, "n.ldPrio", 0, 1, 1, 1, 16'h0009, 8'h05, 16'h0009, 1, 0, 0);
      applyStimulus(1, "n.inc",    0, 0, 0, 1, 16'h0000, 8'h00, 16'h000A, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
